multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multi-cycle successor to the single-cycle main decoder: a Moore FSM that sequences fetch, decode, execute, memory and write-back over several clocks for the OneTactMips datapath.
- Adds a req/ready memory handshake with a parametrised timeout and a sticky error state.
- Sits between the instruction register and the datapath muxes/enables; one instruction retires per FETCH-to-FETCH loop.

Parameters:
- ALUOP_W, 3, width of aluop; codes 000 add, 001 sub, 010 or, 011 slt, 100 and, 111 funct-decoded; upper bits zero-padded when ALUOP_W>3 (ALUOP_W>=3 required).
- TIMEOUT, 255, max cycles mem_req may wait for mem_ready before error; 0 disables timeout.
- TO_W, 8, timeout counter width; must hold TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op_c  in  6  opcode from instruction register
- funct  in  6  funct field from instruction register
- zero  in  1  ALU zero flag (valid in BRANCH)
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  memory write (with mem_req)
- iord  out  1  address select: 0 PC, 1 ALUOut
- ir_we  out  1  instruction register load
- pc_we  out  1  PC write enable
- pc_src  out  2  00 ALU, 01 ALUOut (branch target), 10 jump target, 11 register (jr)
- reg_we  out  1  register file write
- dest_reg_c  out  2  00 rd, 01 rt, 10 $31
- wd_c  out  2  write data: 00 ALUOut, 01 MDR, 10 PC (link)
- argA_c  out  1  0 PC, 1 rs
- argB_c  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
- ext_c  out  2  00 sign, 01 lui (imm<<16), 10 zero
- aluop  out  ALUOP_W  ALU operation code
- state  out  4  current state encoding (debug)
- err  out  1  sticky: timeout or illegal opcode

Behaviour:
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, BNE 000101, J 000010, JAL 000011, ADDI 001000, SLTI 001010, ANDI 001100, ORI 001101, LUI 001111; JR = RTYPE with funct 001000.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REXEC 6, RWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11, ERR 15.
- All outputs are Moore decodes of state; pc_we in BRANCH is also gated by zero and the branch type. Outputs not listed for a state are 0.
- Reset (async, rst_n=0): state=FETCH, err=0, timeout counter=0. All outputs are at their FETCH values immediately.
- FETCH:
  - Outputs: mem_req=1, iord=0, argA_c=0, argB_c=01, aluop=add.
  - Stays in FETCH while mem_ready=0.
  - On mem_ready=1: ir_we=1, pc_we=1, pc_src=00, then go to DECODE.
- DECODE:
  - Outputs: argA_c=0, argB_c=11, aluop=add (branch target into ALUOut).
  - Next state: LW/SW -> MEMADR; RTYPE non-JR -> REXEC; JR -> JUMP; BEQ/BNE -> BRANCH; J/JAL -> JUMP; ADDI/SLTI/ANDI/ORI/LUI -> IEXEC; any other opcode -> ERR.
- MEMADR: argA_c=1, argB_c=10, ext_c=00, aluop=add. Next: LW -> MEMRD, SW -> MEMWR.
- MEMRD: mem_req=1, iord=1; waits for mem_ready, then MEMWB.
- MEMWB: reg_we=1, dest_reg_c=01, wd_c=01, then FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1; waits for mem_ready, then FETCH.
- REXEC: argA_c=1, argB_c=00, aluop=111, then RWB.
- RWB: reg_we=1, dest_reg_c=00, wd_c=00, then FETCH.
- BRANCH:
  - Outputs: argA_c=1, argB_c=00, aluop=sub, pc_src=01.
  - pc_we = (BEQ & zero) | (BNE & ~zero).
  - Next: FETCH.
- JUMP:
  - J: pc_we=1, pc_src=10.
  - JAL: pc_we=1, pc_src=10, reg_we=1, dest_reg_c=10, wd_c=10.
  - JR: pc_we=1, pc_src=11.
  - Next: FETCH.
- IEXEC:
  - Outputs: argA_c=1, argB_c=10.
  - ext_c / aluop per opcode: ADDI 00/add, SLTI 00/slt, ANDI 10/and, ORI 10/or, LUI 01/add.
  - Next: IWB.
- IWB: reg_we=1, dest_reg_c=01, wd_c=00, then FETCH.
- op_c/funct are sampled in every state after FETCH; the IR is stable, so no internal latch is needed.
- Timeout counter:
  - Clears on every state change.
  - Increments each cycle spent in FETCH/MEMRD/MEMWR with mem_ready=0.
  - When it reaches TIMEOUT (TIMEOUT>0) while mem_ready is still 0: next state=ERR, err=1.
  - mem_ready=1 on the same cycle the count reaches TIMEOUT wins: the access completes normally.
- ERR: all enables 0, mem_req=0, err=1. Holds until rst_n=0.
- Reset asserted mid-instruction (including mid-handshake) aborts immediately; mem_req drops asynchronously.

Test Plan:
- ADDI, mem_ready=1 every cycle -> states 0,1,10,11,0. reg_we=1 only in IWB with dest_reg_c=01. pc_we=1 only in FETCH.
- LW with mem_ready held low 3 cycles in MEMRD -> mem_req=1 and iord=1 for 4 cycles, then MEMWB with wd_c=01, reg_we=1. Total 8 cycles.
- BEQ with zero=0, then BNE with zero=0 -> pc_we=0 in BRANCH for BEQ, pc_we=1 with pc_src=01 for BNE. Both return to FETCH.
- JAL -> JUMP: pc_we=1, pc_src=10, reg_we=1, dest_reg_c=10, wd_c=10. RTYPE funct 001000 -> pc_src=11, reg_we=0.
- TIMEOUT=4, mem_ready=0 forever in FETCH -> ERR entered on cycle 5, err=1, state=15. Stays there until rst_n pulse, after which state=0 and err=0.
- Illegal opcode 111111 -> ERR after DECODE. Separately, rst_n low mid-MEMWR -> mem_req=0 with no clock edge.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller, the instruction register and the datapath.
// The master side is the controller; the slave side is the datapath/memory it steers.
interface multicycle_ctrl_if #(
    parameter int ALUOP_W = 3
);
    logic [5:0]         op_c;
    logic [5:0]         funct;
    logic               zero;
    logic               mem_ready;
    logic               mem_req;
    logic               mem_we;
    logic               iord;
    logic               ir_we;
    logic               pc_we;
    logic [1:0]         pc_src;
    logic               reg_we;
    logic [1:0]         dest_reg_c;
    logic [1:0]         wd_c;
    logic               argA_c;
    logic [1:0]         argB_c;
    logic [1:0]         ext_c;
    logic [ALUOP_W-1:0] aluop;
    logic [3:0]         state;
    logic               err;

    modport master (
        input  op_c, funct, zero, mem_ready,
        output mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, dest_reg_c,
               wd_c, argA_c, argB_c, ext_c, aluop, state, err
    );

    modport slave (
        output op_c, funct, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, dest_reg_c,
               wd_c, argA_c, argB_c, ext_c, aluop, state, err
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the multi-cycle OneTactMips datapath: fetch/decode/execute/memory/write-back,
// with a req/ready memory handshake, a wait-cycle timeout and a sticky error state.
//
// state  | meaning
// FETCH  | read instruction at PC, PC += 4 when memory answers
// DECODE | branch target into ALUOut, dispatch on opcode
// MEMADR | rs + sign-extended imm -> ALUOut
// MEMRD  | load access at ALUOut
// MEMWB  | MDR -> rt
// MEMWR  | store access at ALUOut
// REXEC  | R-type ALU op (funct-decoded)
// RWB    | ALUOut -> rd
// BRANCH | rs - rt, conditional PC <- ALUOut
// JUMP   | J / JAL / JR
// IEXEC  | immediate ALU op
// IWB    | ALUOut -> rt
// ERR    | sticky halt until reset
module multicycle_ctrl #(
    parameter int ALUOP_W = 3,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input logic               clk,
    input logic               rst_n,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
        S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_REXEC = 4'd6, S_RWB = 4'd7,
        S_BRANCH = 4'd8, S_JUMP = 4'd9, S_IEXEC = 4'd10, S_IWB = 4'd11,
        S_ERR = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_LUI = 6'b001111;
    localparam logic [5:0] FN_JR = 6'b001000;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3'b011);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b100);
    localparam logic [ALUOP_W-1:0] ALU_FN  = ALUOP_W'(3'b111);
    localparam logic [TO_W-1:0]    TO_MAX  = TO_W'(TIMEOUT);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;
    logic            w_wait;
    logic            w_to_hit;
    logic            w_is_jr;

    assign w_wait   = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_to_hit = (TIMEOUT > 0) && (r_to_cnt == TO_MAX);
    assign w_is_jr  = (bus.op_c == OP_RTYPE) && (bus.funct == FN_JR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= r_err | (w_state_nxt == S_ERR);
            if (w_state_nxt != r_state)
                r_to_cnt <= '0;
            else if (w_wait && !bus.mem_ready && !w_to_hit)
                r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // A ready that arrives on the timeout cycle still completes the access.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH:  if (bus.mem_ready) w_state_nxt = S_DECODE;
                      else if (w_to_hit) w_state_nxt = S_ERR;
            S_DECODE: begin
                case (bus.op_c)
                    OP_LW, OP_SW:   w_state_nxt = S_MEMADR;
                    OP_RTYPE:       w_state_nxt = w_is_jr ? S_JUMP : S_REXEC;
                    OP_BEQ, OP_BNE: w_state_nxt = S_BRANCH;
                    OP_J, OP_JAL:   w_state_nxt = S_JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: w_state_nxt = S_IEXEC;
                    default:        w_state_nxt = S_ERR;
                endcase
            end
            S_MEMADR: w_state_nxt = (bus.op_c == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (bus.mem_ready) w_state_nxt = S_MEMWB;
                      else if (w_to_hit) w_state_nxt = S_ERR;
            S_MEMWR:  if (bus.mem_ready) w_state_nxt = S_FETCH;
                      else if (w_to_hit) w_state_nxt = S_ERR;
            S_REXEC:  w_state_nxt = S_RWB;
            S_IEXEC:  w_state_nxt = S_IWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB: w_state_nxt = S_FETCH;
            S_ERR:    w_state_nxt = S_ERR;
            default:  w_state_nxt = S_ERR;
        endcase
    end

    assign bus.state = r_state;
    assign bus.err   = r_err;

    // mem_req is qualified by rst_n so an aborted access drops without waiting for a clock.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_we      = 1'b0;
        bus.pc_we      = 1'b0;
        bus.pc_src     = 2'b00;
        bus.reg_we     = 1'b0;
        bus.dest_reg_c = 2'b00;
        bus.wd_c       = 2'b00;
        bus.argA_c     = 1'b0;
        bus.argB_c     = 2'b00;
        bus.ext_c      = 2'b00;
        bus.aluop      = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                bus.mem_req = rst_n;
                bus.ir_we   = bus.mem_ready & rst_n;
                bus.pc_we   = bus.mem_ready & rst_n;
                bus.argB_c  = 2'b01;
            end
            S_DECODE: bus.argB_c = 2'b11;
            S_MEMADR: begin
                bus.argA_c = 1'b1;
                bus.argB_c = 2'b10;
            end
            S_MEMRD: begin
                bus.mem_req = rst_n;
                bus.iord    = 1'b1;
            end
            S_MEMWB: begin
                bus.reg_we     = 1'b1;
                bus.dest_reg_c = 2'b01;
                bus.wd_c       = 2'b01;
            end
            S_MEMWR: begin
                bus.mem_req = rst_n;
                bus.mem_we  = 1'b1;
                bus.iord    = 1'b1;
            end
            S_REXEC: begin
                bus.argA_c = 1'b1;
                bus.aluop  = ALU_FN;
            end
            S_RWB: bus.reg_we = 1'b1;
            S_BRANCH: begin
                bus.argA_c = 1'b1;
                bus.aluop  = ALU_SUB;
                bus.pc_src = 2'b01;
                bus.pc_we  = ((bus.op_c == OP_BEQ) & bus.zero) | ((bus.op_c == OP_BNE) & ~bus.zero);
            end
            S_JUMP: begin
                bus.pc_we  = 1'b1;
                bus.pc_src = w_is_jr ? 2'b11 : 2'b10;
                if (bus.op_c == OP_JAL) begin
                    bus.reg_we     = 1'b1;
                    bus.dest_reg_c = 2'b10;
                    bus.wd_c       = 2'b10;
                end
            end
            S_IEXEC: begin
                bus.argA_c = 1'b1;
                bus.argB_c = 2'b10;
                case (bus.op_c)
                    OP_SLTI: bus.aluop = ALU_SLT;
                    OP_ANDI: begin bus.ext_c = 2'b10; bus.aluop = ALU_AND; end
                    OP_ORI:  begin bus.ext_c = 2'b10; bus.aluop = ALU_OR;  end
                    OP_LUI:  bus.ext_c = 2'b01;
                    default: bus.aluop = ALU_ADD;
                endcase
            end
            S_IWB: begin
                bus.reg_we     = 1'b1;
                bus.dest_reg_c = 2'b01;
            end
            default: ;
        endcase
    end

endmodule
